// File: rtl/ddr_arb_pkg.sv
// Shared types and DDR command encodings for the DDR user-port arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RWAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

  localparam logic [2:0] DDR_CMD_RD = 3'd1;
  localparam logic [2:0] DDR_CMD_WR = 3'd0;

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Requester and DDR user-port signals of the arbiter; slave = arbiter side, master = environment side.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic              calib_done_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_rvalid_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [MASK_W-1:0] mem_wmask_i;
  logic              mem_gnt_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_rvalid_o;
  logic              mem_wdone_o;
  logic              ddr_cmd_rdy_i;
  logic              ddr_cmd_en_o;
  logic [2:0]        ddr_cmd_o;
  logic [ADDR_W-1:0] ddr_addr_o;
  logic              ddr_wr_rdy_i;
  logic              ddr_wr_en_o;
  logic [DATA_W-1:0] ddr_wr_data_o;
  logic              ddr_wr_end_o;
  logic [MASK_W-1:0] ddr_wr_mask_o;
  logic [DATA_W-1:0] ddr_rd_data_i;
  logic              ddr_rd_valid_i;
  logic              ddr_rd_end_i;

  modport slave (
    input  calib_done_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
           mem_wdata_i, mem_wmask_i, ddr_cmd_rdy_i, ddr_wr_rdy_i, ddr_rd_data_i,
           ddr_rd_valid_i, ddr_rd_end_i,
    output if_gnt_o, if_rdata_o, if_rvalid_o, mem_gnt_o, mem_rdata_o, mem_rvalid_o,
           mem_wdone_o, ddr_cmd_en_o, ddr_cmd_o, ddr_addr_o, ddr_wr_en_o,
           ddr_wr_data_o, ddr_wr_end_o, ddr_wr_mask_o
  );

  modport master (
    output calib_done_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
           mem_wdata_i, mem_wmask_i, ddr_cmd_rdy_i, ddr_wr_rdy_i, ddr_rd_data_i,
           ddr_rd_valid_i, ddr_rd_end_i,
    input  if_gnt_o, if_rdata_o, if_rvalid_o, mem_gnt_o, mem_rdata_o, mem_rvalid_o,
           mem_wdone_o, ddr_cmd_en_o, ddr_cmd_o, ddr_addr_o, ddr_wr_en_o,
           ddr_wr_data_o, ddr_wr_end_o, ddr_wr_mask_o
  );
endinterface

// File: rtl/ddr_arb_pick.sv
// Winner select between fetch and MEM: MEM-first with starvation guard, or round-robin
// when DDR_ARB_RR_EN is defined. Combinational pick; history updates on grant_i.
module ddr_arb_pick
  import ddr_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req_i,
  input  logic       mem_req_i,
  input  logic       grant_i,
  output arb_owner_t win_o
);

`ifdef DDR_ARB_RR_EN
  arb_owner_t last_q;

  // The side granted last loses the next tie.
  always_comb begin
    win_o = OWN_IF;
    if (mem_req_i && (!if_req_i || last_q == OWN_IF)) win_o = OWN_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= OWN_IF;
    else if (grant_i) last_q <= win_o;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    win_o = OWN_IF;
    if (mem_req_i && !(if_req_i && starve_q == CNT_MAX)) win_o = OWN_MEM;
    starve_d = starve_q;
    if (grant_i) begin
      if (win_o == OWN_IF)                         starve_d = '0;
      else if (if_req_i && starve_q != CNT_MAX)    starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR3 user port between fetch (read) and MEM (read/write), one transaction at a time.
// Latency: gnt one cycle after request seen in IDLE, cmd_en one cycle after gnt. Option: DDR_ARB_RR_EN.
// Backpressure: cmd_en / wr_en held until cmd_rdy / wr_rdy; requesters hold req until their gnt.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int MASK_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  ddr_port_arbiter_if.slave arb_if
);

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  arb_owner_t        win;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_gnt_q, mem_gnt_q, cmd_en_q, wr_en_q, wdone_q;
  logic              if_rvalid_q, mem_rvalid_q;
  logic              grant;

  assign grant = (state_q == IDLE) && arb_if.calib_done_i && (arb_if.if_req_i || arb_if.mem_req_i);

  ddr_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req_i  (arb_if.if_req_i),
    .mem_req_i (arb_if.mem_req_i),
    .grant_i   (grant),
    .win_o     (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_gnt_q     <= 1'b0;
      mem_gnt_q    <= 1'b0;
      cmd_en_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wdone_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
    end else begin
      if_gnt_q     <= 1'b0;
      mem_gnt_q    <= 1'b0;
      wdone_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          owner_q <= win;
          state_q <= CMD;
          if (win == OWN_MEM) begin
            mem_gnt_q <= 1'b1;
            cmd_q     <= arb_if.mem_we_i ? DDR_CMD_WR : DDR_CMD_RD;
            addr_q    <= arb_if.mem_addr_i;
            wdata_q   <= arb_if.mem_wdata_i;
            mask_q    <= arb_if.mem_wmask_i;
          end else begin
            if_gnt_q  <= 1'b1;
            cmd_q     <= DDR_CMD_RD;
            addr_q    <= arb_if.if_addr_i;
          end
        end
        // First CMD cycle only raises cmd_en, giving the one-cycle gnt->cmd_en spacing.
        CMD: begin
          if (!cmd_en_q) begin
            cmd_en_q <= 1'b1;
          end else if (arb_if.ddr_cmd_rdy_i) begin
            cmd_en_q <= 1'b0;
            if (cmd_q == DDR_CMD_WR) begin
              wr_en_q <= 1'b1;
              state_q <= WDATA;
            end else begin
              state_q <= RWAIT;
            end
          end
        end
        WDATA: if (arb_if.ddr_wr_rdy_i) begin
          wr_en_q <= 1'b0;
          wdone_q <= 1'b1;
          state_q <= IDLE;
        end
        RWAIT: if (arb_if.ddr_rd_valid_i) begin
          if (owner_q == OWN_MEM) begin
            mem_rdata_q  <= arb_if.ddr_rd_data_i;
            mem_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q   <= arb_if.ddr_rd_data_i;
            if_rvalid_q  <= 1'b1;
          end
          if (arb_if.ddr_rd_end_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_if.if_gnt_o      = if_gnt_q;
  assign arb_if.if_rdata_o    = if_rdata_q;
  assign arb_if.if_rvalid_o   = if_rvalid_q;
  assign arb_if.mem_gnt_o     = mem_gnt_q;
  assign arb_if.mem_rdata_o   = mem_rdata_q;
  assign arb_if.mem_rvalid_o  = mem_rvalid_q;
  assign arb_if.mem_wdone_o   = wdone_q;
  assign arb_if.ddr_cmd_en_o  = cmd_en_q;
  assign arb_if.ddr_cmd_o     = cmd_q;
  assign arb_if.ddr_addr_o    = addr_q;
  assign arb_if.ddr_wr_en_o   = wr_en_q;
  assign arb_if.ddr_wr_end_o  = wr_en_q;
  assign arb_if.ddr_wr_data_o = wdata_q;
  assign arb_if.ddr_wr_mask_o = mask_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: calibration gate, read/write handshakes, arbitration, reset.
module tb_ddr_port_arbiter;
  import ddr_arb_pkg::*;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.calib_done_i = 0; bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_addr_i = '0;
    bus.mem_wdata_i = '0; bus.mem_wmask_i = '0;
    bus.ddr_cmd_rdy_i = 0; bus.ddr_wr_rdy_i = 0; bus.ddr_rd_data_i = '0;
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.if_gnt_o, bus.mem_gnt_o, bus.ddr_cmd_en_o, bus.ddr_wr_en_o, bus.ddr_wr_end_o,
         bus.if_rvalid_o, bus.mem_rvalid_o, bus.mem_wdone_o} !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000000", {bus.if_gnt_o, bus.mem_gnt_o,
        bus.ddr_cmd_en_o, bus.ddr_wr_en_o, bus.ddr_wr_end_o, bus.if_rvalid_o, bus.mem_rvalid_o, bus.mem_wdone_o});
    end
    n_cmp++;
    if (bus.ddr_cmd_o !== 3'd0 || bus.ddr_addr_o !== '0 || bus.ddr_wr_mask_o !== '0) begin
      n_fail++; $display("FAIL reset_cmd: cmd %0d addr %h mask %h want all 0", bus.ddr_cmd_o, bus.ddr_addr_o, bus.ddr_wr_mask_o);
    end
    n_cmp++;
    if (bus.ddr_wr_data_o !== '0 || bus.if_rdata_o !== '0 || bus.mem_rdata_o !== '0) begin
      n_fail++; $display("FAIL reset_data: wr/if/mem data not 0");
    end
    n_cmp++;
    if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_calib_gate();
    int gnts = 0;
    logic [DATA_W-1:0] d;
    d = {8{32'h1111_2222}};
    bus.if_req_i = 1; bus.if_addr_i = 29'h0000040;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.if_gnt_o || bus.mem_gnt_o) gnts++;
    end
    n_cmp++;
    if (gnts !== 0) begin n_fail++; $display("FAIL calib_gate: got %0d grants want 0", gnts); end
    bus.calib_done_i = 1;
    tick();
    n_cmp++;
    if (bus.if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL calib_gnt: got %b want 1", bus.if_gnt_o); end
    bus.if_req_i = 0;
    tick();
    n_cmp++;
    if (bus.ddr_cmd_en_o !== 1'b1 || bus.ddr_cmd_o !== 3'd1 || bus.ddr_addr_o !== 29'h0000040) begin
      n_fail++; $display("FAIL calib_cmd: en %b cmd %0d addr %h want 1 1 0000040", bus.ddr_cmd_en_o, bus.ddr_cmd_o, bus.ddr_addr_o);
    end
    bus.ddr_cmd_rdy_i = 1;
    tick();
    bus.ddr_cmd_rdy_i = 0;
    n_cmp++;
    if (bus.ddr_cmd_en_o !== 1'b0) begin n_fail++; $display("FAIL calib_cmd_drop: got %b want 0", bus.ddr_cmd_en_o); end
    bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1; bus.ddr_rd_data_i = d;
    tick();
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    n_cmp++;
    if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== d) begin
      n_fail++; $display("FAIL calib_rdata: rvalid %b data %h want 1 %h", bus.if_rvalid_o, bus.if_rdata_o, d);
    end
    tick();
    n_cmp++;
    if (bus.if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL calib_rvalid_pulse: got %b want 0", bus.if_rvalid_o); end
  endtask

  task automatic test_write();
    int cnt = 0, bad = 0, done = 0;
    logic [DATA_W-1:0] wd;
    wd = {8{32'hDEAD_BEEF}};
    bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_addr_i = 29'h0001000;
    bus.mem_wdata_i = wd; bus.mem_wmask_i = '0;
    tick();
    n_cmp++;
    if (bus.mem_gnt_o !== 1'b1 || bus.if_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_gnt: mem %b if %b want 1 0", bus.mem_gnt_o, bus.if_gnt_o);
    end
    bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_wdata_i = '0;
    tick();
    n_cmp++;
    if (bus.ddr_cmd_en_o !== 1'b1 || bus.ddr_cmd_o !== 3'd0 || bus.ddr_addr_o !== 29'h0001000) begin
      n_fail++; $display("FAIL wr_cmd: en %b cmd %0d addr %h want 1 0 0001000", bus.ddr_cmd_en_o, bus.ddr_cmd_o, bus.ddr_addr_o);
    end
    bus.ddr_cmd_rdy_i = 1;
    tick();
    bus.ddr_cmd_rdy_i = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.mem_wdone_o) done++;
      if (bus.ddr_wr_en_o) begin
        cnt++;
        if (bus.ddr_wr_end_o !== 1'b1 || bus.ddr_wr_data_o !== wd || bus.ddr_wr_mask_o !== '0) bad++;
      end else if (cnt > 0) begin
        break;
      end
      bus.ddr_wr_rdy_i = (cnt == 3);
      tick();
    end
    bus.ddr_wr_rdy_i = 0;
    tick();
    if (bus.mem_wdone_o) done++;
    n_cmp++;
    if (cnt !== 3) begin n_fail++; $display("FAIL wr_en_len: got %0d cycles want 3", cnt); end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wr_beat: got %0d bad cycles want 0", bad); end
    n_cmp++;
    if (done !== 1) begin n_fail++; $display("FAIL wr_done: got %0d pulses want 1", done); end
    n_cmp++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL wr_idle: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_read_backpressure();
    int cnt = 0, bad = 0;
    logic [DATA_W-1:0] a5, x5a;
    a5  = {32{8'hA5}};
    x5a = {32{8'h5A}};
    bus.if_req_i = 1; bus.if_addr_i = 29'h0000100;
    tick();
    n_cmp++;
    if (bus.if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", bus.if_gnt_o); end
    bus.if_req_i = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.ddr_cmd_en_o) begin
        cnt++;
        if (bus.ddr_cmd_o !== 3'd1 || bus.ddr_addr_o !== 29'h0000100) bad++;
      end else if (cnt > 0) begin
        break;
      end
      bus.ddr_cmd_rdy_i = (cnt == 4);
    end
    bus.ddr_cmd_rdy_i = 0;
    n_cmp++;
    if (cnt !== 4 || bad !== 0) begin
      n_fail++; $display("FAIL rd_cmd_hold: got %0d cycles %0d bad want 4 0", cnt, bad);
    end
    bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1; bus.ddr_rd_data_i = a5;
    tick();
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    n_cmp++;
    if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== a5) begin
      n_fail++; $display("FAIL rd_data: rvalid %b data %h want 1 %h", bus.if_rvalid_o, bus.if_rdata_o, a5);
    end
    n_cmp++;
    if (bus.mem_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_mem_rvalid: got %b want 0", bus.mem_rvalid_o); end
    tick();
    bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1; bus.ddr_rd_data_i = x5a;
    tick();
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    n_cmp++;
    if (bus.if_rvalid_o !== 1'b0 || bus.mem_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_stray_valid: if %b mem %b want 0 0", bus.if_rvalid_o, bus.mem_rvalid_o);
    end
    n_cmp++;
    if (bus.if_rdata_o !== a5) begin n_fail++; $display("FAIL rd_hold: got %h want %h", bus.if_rdata_o, a5); end
  endtask

  task automatic test_contention();
    arb_owner_t exp [5];
    arb_owner_t got [$];
    int both = 0;
`ifdef DDR_ARB_RR_EN
    exp = '{OWN_MEM, OWN_IF, OWN_MEM, OWN_IF, OWN_MEM};
`else
    exp = '{OWN_MEM, OWN_MEM, OWN_MEM, OWN_MEM, OWN_IF};
`endif
    bus.ddr_cmd_rdy_i = 1; bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1;
    bus.ddr_rd_data_i = {8{32'h0BAD_CAFE}};
    bus.if_addr_i = 29'h0000400; bus.mem_addr_i = 29'h0000800; bus.mem_we_i = 0;
    bus.if_req_i = 1; bus.mem_req_i = 1;
    for (int i = 0; i < 100 && got.size() < 5; i++) begin
      tick();
      if (bus.if_gnt_o && bus.mem_gnt_o) both++;
      else if (bus.mem_gnt_o)            got.push_back(OWN_MEM);
      else if (bus.if_gnt_o)             got.push_back(OWN_IF);
    end
    bus.if_req_i = 0; bus.mem_req_i = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got.size()) begin
        n_fail++; $display("FAIL arb_order%0d: got no grant want %s", i, exp[i].name());
      end else if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL arb_order%0d: got %s want %s", i, got[i].name(), exp[i].name());
      end
    end
    n_cmp++;
    if (both !== 0) begin n_fail++; $display("FAIL arb_double_gnt: got %0d want 0", both); end
    repeat (6) tick();
    bus.ddr_cmd_rdy_i = 0; bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    tick();
    n_cmp++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL arb_drain: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    d = {8{32'h3C3C_0F0F}};
    bus.if_req_i = 1; bus.if_addr_i = 29'h0000200; bus.ddr_cmd_rdy_i = 1;
    tick();
    bus.if_req_i = 0;
    repeat (2) tick();
    n_cmp++;
    if (dut.state_q !== RWAIT) begin n_fail++; $display("FAIL rst_pre: got %0d want RWAIT", dut.state_q); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ddr_cmd_en_o, bus.ddr_cmd_o, bus.ddr_addr_o, bus.if_rdata_o, bus.mem_rdata_o} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: cmd_en %b cmd %0d addr %h want all 0", bus.ddr_cmd_en_o, bus.ddr_cmd_o, bus.ddr_addr_o);
    end
    bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1; bus.ddr_rd_data_i = {8{32'h7777_7777}};
    tick();
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    n_cmp++;
    if (bus.if_rvalid_o !== 1'b0 || bus.mem_rvalid_o !== 1'b0 || bus.if_rdata_o !== '0) begin
      n_fail++; $display("FAIL rst_drop: if_rvalid %b mem_rvalid %b if_rdata %h want 0 0 0", bus.if_rvalid_o, bus.mem_rvalid_o, bus.if_rdata_o);
    end
    rst_n = 1'b1;
    tick();
    bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 29'h0000300;
    tick();
    n_cmp++;
    if (bus.mem_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rst_regrant: got %b want 1", bus.mem_gnt_o); end
    bus.mem_req_i = 0;
    tick();
    n_cmp++;
    if (bus.ddr_cmd_en_o !== 1'b1 || bus.ddr_cmd_o !== 3'd1 || bus.ddr_addr_o !== 29'h0000300) begin
      n_fail++; $display("FAIL rst_cmd: en %b cmd %0d addr %h want 1 1 0000300", bus.ddr_cmd_en_o, bus.ddr_cmd_o, bus.ddr_addr_o);
    end
    tick();
    bus.ddr_cmd_rdy_i = 0;
    bus.ddr_rd_valid_i = 1; bus.ddr_rd_end_i = 1; bus.ddr_rd_data_i = d;
    tick();
    bus.ddr_rd_valid_i = 0; bus.ddr_rd_end_i = 0;
    n_cmp++;
    if (bus.mem_rvalid_o !== 1'b1 || bus.mem_rdata_o !== d || bus.if_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem_read: mem_rvalid %b if_rvalid %b data %h want 1 0 %h", bus.mem_rvalid_o, bus.if_rvalid_o, bus.mem_rdata_o, d);
    end
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_write();
    test_read_backpressure();
    test_contention();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
